// File: rtl/ex_mem_stage.sv
// ----------------------------------------------------------------------------
// ex_mem_stage
//
// EX/MEM pipeline boundary.
//  * Registers the EX-stage results (ALU result, store data, destination,
//    branch target, MEM/WB control bits) into the M stage and registers the
//    branch decision PCSrc = Branch & Zero.
//  * Drives the forwarded operands readd1/readd2 back into EX, selecting
//    MEM-stage result, WB-stage data or raw register-file data.
//  * Detects load-use hazards and inserts bubbles for hazards, taken
//    branches and external flushes.
//
// Ports
//  clk, rst                 clock, synchronous active-high reset
//  stall                    hold every M-stage register
//  flush                    next capture is a bubble (wins over stall)
//  rf_d1, rf_d2             raw register-file operands of the EX instruction
//  ex_rs, ex_rt             EX source register addresses
//  ALUResult, Zero          EX ALU result and zero flag
//  WriteReg, ALUR           EX destination register and branch target
//  RegWrite..Branch         EX control bits
//  wb_RegWrite/WriteReg/data  WB-stage write-back port (forwarding source)
//  readd1, readd2           forwarded operands to EX (combinational)
//  ld_hazard                load-use hazard, upstream holds IF/ID/EX
//  m_*                      registered M-stage outputs
//  PCSrc                    registered branch-taken flag
// ----------------------------------------------------------------------------
module ex_mem_stage #(
   parameter int ALU_WIDTH     = 8,
   parameter int PC_WIDTH      = 6,
   parameter int REG_DIR_WIDTH = 3
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     flush,
   input  logic [ALU_WIDTH-1:0]     rf_d1,
   input  logic [ALU_WIDTH-1:0]     rf_d2,
   input  logic [REG_DIR_WIDTH-1:0] ex_rs,
   input  logic [REG_DIR_WIDTH-1:0] ex_rt,
   input  logic [ALU_WIDTH-1:0]     ALUResult,
   input  logic                     Zero,
   input  logic [REG_DIR_WIDTH-1:0] WriteReg,
   input  logic [PC_WIDTH-1:0]      ALUR,
   input  logic                     RegWrite,
   input  logic                     MemRead,
   input  logic                     MemWrite,
   input  logic                     MemtoReg,
   input  logic                     Branch,
   input  logic                     wb_RegWrite,
   input  logic [REG_DIR_WIDTH-1:0] wb_WriteReg,
   input  logic [ALU_WIDTH-1:0]     wb_data,
   output logic [ALU_WIDTH-1:0]     readd1,
   output logic [ALU_WIDTH-1:0]     readd2,
   output logic                     ld_hazard,
   output logic [ALU_WIDTH-1:0]     m_ALUResult,
   output logic [ALU_WIDTH-1:0]     m_WriteData,
   output logic [REG_DIR_WIDTH-1:0] m_WriteReg,
   output logic                     m_RegWrite,
   output logic                     m_MemRead,
   output logic                     m_MemWrite,
   output logic                     m_MemtoReg,
   output logic [PC_WIDTH-1:0]      m_ALUR,
   output logic                     PCSrc
);

   // M-stage state
   logic [ALU_WIDTH-1:0]     alu_q, alu_d;
   logic [ALU_WIDTH-1:0]     wdata_q, wdata_d;
   logic [REG_DIR_WIDTH-1:0] wreg_q, wreg_d;
   logic [PC_WIDTH-1:0]      alur_q, alur_d;
   logic                     regwrite_q, regwrite_d;
   logic                     memread_q, memread_d;
   logic                     memwrite_q, memwrite_d;
   logic                     memtoreg_q, memtoreg_d;
   logic                     pcsrc_q, pcsrc_d;

   // ------------------------------------------------------------------------
   // Operand forwarding. Index 0 is operand A (rs), index 1 is operand B (rt).
   // A load in M has no data yet, so it is excluded from MEM forwarding;
   // that case is covered by the load-use bubble instead.
   // ------------------------------------------------------------------------
   logic [REG_DIR_WIDTH-1:0] src_reg [2];
   logic [ALU_WIDTH-1:0]     src_rf  [2];
   logic [ALU_WIDTH-1:0]     fwd     [2];

   assign src_reg[0] = ex_rs;
   assign src_reg[1] = ex_rt;
   assign src_rf[0]  = rf_d1;
   assign src_rf[1]  = rf_d2;

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_fwd
         always_comb begin
            fwd[gi] = src_rf[gi];
            if (src_reg[gi] != '0) begin
               if (regwrite_q && !memread_q && (wreg_q == src_reg[gi]))
                  fwd[gi] = alu_q;
               else if (wb_RegWrite && (wb_WriteReg == src_reg[gi]))
                  fwd[gi] = wb_data;
            end
         end
      end
   endgenerate

   assign readd1 = fwd[0];
   assign readd2 = fwd[1];

   assign ld_hazard = memread_q && regwrite_q && (wreg_q != '0) &&
                      ((wreg_q == ex_rs) || (wreg_q == ex_rt));

   // ------------------------------------------------------------------------
   // Next-state selection: flush > stall > taken branch > load-use > capture.
   // Flush outranks stall so an external kill is never swallowed by a hold.
   // ------------------------------------------------------------------------
   always_comb begin
      alu_d      = alu_q;
      wdata_d    = wdata_q;
      wreg_d     = wreg_q;
      alur_d     = alur_q;
      regwrite_d = regwrite_q;
      memread_d  = memread_q;
      memwrite_d = memwrite_q;
      memtoreg_d = memtoreg_q;
      pcsrc_d    = pcsrc_q;
      if (flush || (!stall && (pcsrc_q || ld_hazard))) begin
         // bubble: controls and data all cleared
         alu_d      = '0;
         wdata_d    = '0;
         wreg_d     = '0;
         alur_d     = '0;
         regwrite_d = 1'b0;
         memread_d  = 1'b0;
         memwrite_d = 1'b0;
         memtoreg_d = 1'b0;
         pcsrc_d    = 1'b0;
      end else if (!stall) begin
         alu_d      = ALUResult;
         wdata_d    = fwd[1];
         wreg_d     = WriteReg;
         alur_d     = ALUR;
         regwrite_d = RegWrite;
         memread_d  = MemRead;
         memwrite_d = MemWrite;
         memtoreg_d = MemtoReg;
         pcsrc_d    = Branch & Zero;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         alu_q      <= '0;
         wdata_q    <= '0;
         wreg_q     <= '0;
         alur_q     <= '0;
         regwrite_q <= 1'b0;
         memread_q  <= 1'b0;
         memwrite_q <= 1'b0;
         memtoreg_q <= 1'b0;
         pcsrc_q    <= 1'b0;
      end else begin
         alu_q      <= alu_d;
         wdata_q    <= wdata_d;
         wreg_q     <= wreg_d;
         alur_q     <= alur_d;
         regwrite_q <= regwrite_d;
         memread_q  <= memread_d;
         memwrite_q <= memwrite_d;
         memtoreg_q <= memtoreg_d;
         pcsrc_q    <= pcsrc_d;
      end
   end

   assign m_ALUResult = alu_q;
   assign m_WriteData = wdata_q;
   assign m_WriteReg  = wreg_q;
   assign m_ALUR      = alur_q;
   assign m_RegWrite  = regwrite_q;
   assign m_MemRead   = memread_q;
   assign m_MemWrite  = memwrite_q;
   assign m_MemtoReg  = memtoreg_q;
   assign PCSrc       = pcsrc_q;

endmodule

// File: tb/tb_ex_mem_stage.sv
// ----------------------------------------------------------------------------
// tb_ex_mem_stage
//
// Directed table of {inputs, expected outputs} walking through reset,
// forwarding, load-use, branch, stall and flush cases, followed by a
// randomized run compared against a behavioural model of the M stage.
// ----------------------------------------------------------------------------
module tb_ex_mem_stage;

   logic       clk = 1'b0;
   logic       rst, stall, flush;
   logic [7:0] rf_d1, rf_d2, ALUResult, wb_data;
   logic [2:0] ex_rs, ex_rt, WriteReg, wb_WriteReg;
   logic [5:0] ALUR;
   logic       Zero, RegWrite, MemRead, MemWrite, MemtoReg, Branch, wb_RegWrite;
   logic [7:0] readd1, readd2, m_ALUResult, m_WriteData;
   logic       ld_hazard, m_RegWrite, m_MemRead, m_MemWrite, m_MemtoReg, PCSrc;
   logic [2:0] m_WriteReg;
   logic [5:0] m_ALUR;

   always #5 clk = ~clk;

   ex_mem_stage #(.ALU_WIDTH(8), .PC_WIDTH(6), .REG_DIR_WIDTH(3)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .rf_d1(rf_d1), .rf_d2(rf_d2), .ex_rs(ex_rs), .ex_rt(ex_rt),
      .ALUResult(ALUResult), .Zero(Zero), .WriteReg(WriteReg), .ALUR(ALUR),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
      .MemtoReg(MemtoReg), .Branch(Branch),
      .wb_RegWrite(wb_RegWrite), .wb_WriteReg(wb_WriteReg), .wb_data(wb_data),
      .readd1(readd1), .readd2(readd2), .ld_hazard(ld_hazard),
      .m_ALUResult(m_ALUResult), .m_WriteData(m_WriteData),
      .m_WriteReg(m_WriteReg), .m_RegWrite(m_RegWrite),
      .m_MemRead(m_MemRead), .m_MemWrite(m_MemWrite),
      .m_MemtoReg(m_MemtoReg), .m_ALUR(m_ALUR), .PCSrc(PCSrc)
   );

   typedef struct packed {
      logic       rst, stall, flush;
      logic [7:0] rf_d1, rf_d2;
      logic [2:0] ex_rs, ex_rt;
      logic [7:0] alu;
      logic       zero;
      logic [2:0] wreg;
      logic [5:0] alur;
      logic       rw, mr, mw, m2r, br, wb_rw;
      logic [2:0] wb_wr;
      logic [7:0] wb_data;
      // expectations
      logic       chk_comb;
      logic [7:0] e_rd1, e_rd2;
      logic       e_ld, e_rw, e_mr, e_mw, e_m2r;
      logic [7:0] e_alu, e_wd;
      logic [2:0] e_wr;
      logic [5:0] e_alur;
      logic       e_pcs;
   } rec_t;

   int checks   = 0;
   int failures = 0;
   rec_t tbl[$];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input rec_t r);
      rst = r.rst; stall = r.stall; flush = r.flush;
      rf_d1 = r.rf_d1; rf_d2 = r.rf_d2; ex_rs = r.ex_rs; ex_rt = r.ex_rt;
      ALUResult = r.alu; Zero = r.zero; WriteReg = r.wreg; ALUR = r.alur;
      RegWrite = r.rw; MemRead = r.mr; MemWrite = r.mw; MemtoReg = r.m2r;
      Branch = r.br; wb_RegWrite = r.wb_rw; wb_WriteReg = r.wb_wr;
      wb_data = r.wb_data;
   endtask

   // ---------------- behavioural model of the M stage ----------------
   int s_rw, s_mr, s_mw, s_m2r, s_pcs, s_alu, s_wd, s_wr, s_alur;

   function automatic int mdl_fwd(int rs, int rf, int wbrw, int wbwr, int wbd);
      if (rs == 0) return rf;
      if (s_rw == 1 && s_mr == 0 && s_wr == rs) return s_alu;
      if (wbrw == 1 && wbwr == rs) return wbd;
      return rf;
   endfunction

   function automatic int mdl_haz(int rs, int rt);
      return (s_mr == 1 && s_rw == 1 && s_wr != 0 && (s_wr == rs || s_wr == rt)) ? 1 : 0;
   endfunction

   task automatic mdl_clear();
      s_rw = 0; s_mr = 0; s_mw = 0; s_m2r = 0; s_pcs = 0;
      s_alu = 0; s_wd = 0; s_wr = 0; s_alur = 0;
   endtask

   task automatic mdl_step(input rec_t r);
      int st_b;
      int haz;
      st_b = mdl_fwd(r.ex_rt, r.rf_d2, r.wb_rw, r.wb_wr, r.wb_data);
      haz  = mdl_haz(r.ex_rs, r.ex_rt);
      if (r.rst || r.flush) mdl_clear();
      else if (r.stall) ;
      else if (s_pcs == 1 || haz == 1) mdl_clear();
      else begin
         s_rw = r.rw; s_mr = r.mr; s_mw = r.mw; s_m2r = r.m2r;
         s_pcs = (r.br && r.zero) ? 1 : 0;
         s_alu = r.alu; s_wd = st_b; s_wr = r.wreg; s_alur = r.alur;
      end
   endtask

   initial begin
      rec_t r;
      rec_t z;
      z = '0;
      drive(z);

      // 0: reset with every input at 1
      r = '1; r.chk_comb = 0;
      r.e_rd1 = 0; r.e_rd2 = 0; r.e_ld = 0; r.e_rw = 0; r.e_mr = 0; r.e_mw = 0;
      r.e_m2r = 0; r.e_alu = 0; r.e_wd = 0; r.e_wr = 0; r.e_alur = 0; r.e_pcs = 0;
      tbl.push_back(r);
      // 1: M gets reg3 <- 0x2A
      r = '0; r.chk_comb = 1; r.rw = 1; r.wreg = 3; r.alu = 8'h2A;
      r.e_rw = 1; r.e_alu = 8'h2A; r.e_wr = 3;
      tbl.push_back(r);
      // 2: MEM forward to rs; capture reg5 <- 0x11
      r = '0; r.chk_comb = 1; r.ex_rs = 3; r.rf_d1 = 8'h05; r.rf_d2 = 8'h07;
      r.rw = 1; r.wreg = 5; r.alu = 8'h11;
      r.e_rd1 = 8'h2A; r.e_rd2 = 8'h07;
      r.e_rw = 1; r.e_alu = 8'h11; r.e_wd = 8'h07; r.e_wr = 5;
      tbl.push_back(r);
      // 3: MEM beats WB on rt; store data takes forwarded value
      r = '0; r.chk_comb = 1; r.ex_rt = 5; r.rf_d2 = 8'h33; r.rf_d1 = 8'h44;
      r.wb_rw = 1; r.wb_wr = 5; r.wb_data = 8'h22;
      r.rw = 1; r.wreg = 0; r.alu = 8'h99;
      r.e_rd1 = 8'h44; r.e_rd2 = 8'h11;
      r.e_rw = 1; r.e_alu = 8'h99; r.e_wd = 8'h11; r.e_wr = 0;
      tbl.push_back(r);
      // 4: register 0 never forwarded; capture load reg2
      r = '0; r.chk_comb = 1; r.rf_d1 = 8'h05; r.rf_d2 = 8'h06;
      r.wb_rw = 1; r.wb_wr = 0; r.wb_data = 8'h77;
      r.rw = 1; r.mr = 1; r.m2r = 1; r.wreg = 2; r.alu = 8'h40;
      r.e_rd1 = 8'h05; r.e_rd2 = 8'h06;
      r.e_rw = 1; r.e_mr = 1; r.e_m2r = 1; r.e_alu = 8'h40; r.e_wd = 8'h06; r.e_wr = 2;
      tbl.push_back(r);
      // 5: load-use on rt -> bubble
      r = '0; r.chk_comb = 1; r.ex_rs = 1; r.rf_d1 = 8'h09; r.ex_rt = 2; r.rf_d2 = 8'h08;
      r.rw = 1; r.wreg = 6; r.alu = 8'h55;
      r.e_rd1 = 8'h09; r.e_rd2 = 8'h08; r.e_ld = 1;
      tbl.push_back(r);
      // 6: held instruction now forwards from WB
      r.wb_rw = 1; r.wb_wr = 2; r.wb_data = 8'h3C;
      r.e_rd2 = 8'h3C; r.e_ld = 0;
      r.e_rw = 1; r.e_alu = 8'h55; r.e_wd = 8'h3C; r.e_wr = 6;
      tbl.push_back(r);
      // 7: taken branch
      r = '0; r.chk_comb = 1; r.br = 1; r.zero = 1; r.alur = 6'h1C; r.alu = 8'h10;
      r.rf_d1 = 8'h01; r.rf_d2 = 8'h02;
      r.e_rd1 = 8'h01; r.e_rd2 = 8'h02;
      r.e_pcs = 1; r.e_alur = 6'h1C; r.e_alu = 8'h10; r.e_wd = 8'h02;
      tbl.push_back(r);
      // 8: wrong-path instruction killed
      r = '0; r.chk_comb = 1; r.rw = 1; r.wreg = 4; r.alu = 8'h66;
      r.rf_d1 = 8'h03; r.rf_d2 = 8'h04;
      r.e_rd1 = 8'h03; r.e_rd2 = 8'h04;
      tbl.push_back(r);
      // 9: same instruction captured normally
      r.e_rw = 1; r.e_alu = 8'h66; r.e_wd = 8'h04; r.e_wr = 4;
      tbl.push_back(r);
      // 10..12: stall with changing EX inputs -> hold
      for (int i = 0; i < 3; i++) begin
         r = '0; r.chk_comb = 1; r.stall = 1; r.alu = 8'hA1 + 8'(i);
         r.wreg = 1; r.mr = 1; r.br = 1; r.zero = 1; r.alur = 6'h3F;
         r.rf_d1 = 8'h10; r.rf_d2 = 8'h20;
         r.e_rd1 = 8'h10; r.e_rd2 = 8'h20;
         r.e_rw = 1; r.e_alu = 8'h66; r.e_wd = 8'h04; r.e_wr = 4;
         tbl.push_back(r);
      end
      // 13: flush together with stall -> bubble
      r.flush = 1;
      r.e_rw = 0; r.e_alu = 0; r.e_wd = 0; r.e_wr = 0;
      tbl.push_back(r);
      // 14: taken branch that is also a load to reg3
      r = '0; r.chk_comb = 1; r.br = 1; r.zero = 1; r.alur = 6'h2B;
      r.rw = 1; r.mr = 1; r.wreg = 3; r.alu = 8'h12; r.rf_d2 = 8'h05;
      r.e_rd2 = 8'h05;
      r.e_pcs = 1; r.e_rw = 1; r.e_mr = 1; r.e_wr = 3; r.e_alur = 6'h2B;
      r.e_alu = 8'h12; r.e_wd = 8'h05;
      tbl.push_back(r);
      // 15: stall with hazard pending -> PCSrc and everything held
      r = '0; r.chk_comb = 1; r.stall = 1; r.ex_rs = 3; r.rf_d1 = 8'h0A; r.rf_d2 = 8'h0B;
      r.rw = 1; r.wreg = 7; r.alu = 8'hEE;
      r.e_rd1 = 8'h0A; r.e_rd2 = 8'h0B; r.e_ld = 1;
      r.e_pcs = 1; r.e_rw = 1; r.e_mr = 1; r.e_wr = 3; r.e_alur = 6'h2B;
      r.e_alu = 8'h12; r.e_wd = 8'h05;
      tbl.push_back(r);
      // 16: release stall: hazard and PCSrc together -> bubble
      r.stall = 0;
      r.e_pcs = 0; r.e_rw = 0; r.e_mr = 0; r.e_wr = 0; r.e_alur = 0;
      r.e_alu = 0; r.e_wd = 0;
      tbl.push_back(r);

      // ---------------- directed table ----------------
      foreach (tbl[i]) begin
         @(negedge clk);
         drive(tbl[i]);
         #1;
         if (tbl[i].chk_comb) begin
            chk($sformatf("row%0d readd1", i), readd1, tbl[i].e_rd1);
            chk($sformatf("row%0d readd2", i), readd2, tbl[i].e_rd2);
            chk($sformatf("row%0d ld_hazard", i), ld_hazard, tbl[i].e_ld);
         end
         @(posedge clk);
         #1;
         chk($sformatf("row%0d m_RegWrite", i), m_RegWrite, tbl[i].e_rw);
         chk($sformatf("row%0d m_MemRead", i), m_MemRead, tbl[i].e_mr);
         chk($sformatf("row%0d m_MemWrite", i), m_MemWrite, tbl[i].e_mw);
         chk($sformatf("row%0d m_MemtoReg", i), m_MemtoReg, tbl[i].e_m2r);
         chk($sformatf("row%0d m_ALUResult", i), m_ALUResult, tbl[i].e_alu);
         chk($sformatf("row%0d m_WriteData", i), m_WriteData, tbl[i].e_wd);
         chk($sformatf("row%0d m_WriteReg", i), m_WriteReg, tbl[i].e_wr);
         chk($sformatf("row%0d m_ALUR", i), m_ALUR, tbl[i].e_alur);
         chk($sformatf("row%0d PCSrc", i), PCSrc, tbl[i].e_pcs);
         $display("row %0d rst=%0d stall=%0d flush=%0d rd1=%02h rd2=%02h ld=%0d m_rw=%0d m_alu=%02h m_wd=%02h pcs=%0d",
                  i, tbl[i].rst, tbl[i].stall, tbl[i].flush, readd1, readd2,
                  ld_hazard, m_RegWrite, m_ALUResult, m_WriteData, PCSrc);
      end

      // ---------------- randomized run against the model ----------------
      mdl_clear();
      for (int n = 0; n < 400; n++) begin
         int e1, e2, eh;
         r = '0;
         r.rst   = (n == 0) || ($urandom_range(0, 31) == 0);
         r.stall = ($urandom_range(0, 3) == 0);
         r.flush = ($urandom_range(0, 9) == 0);
         r.rf_d1 = 8'($urandom); r.rf_d2 = 8'($urandom);
         r.ex_rs = 3'($urandom_range(0, 3)); r.ex_rt = 3'($urandom_range(0, 3));
         r.alu = 8'($urandom); r.zero = 1'($urandom);
         r.wreg = 3'($urandom_range(0, 3)); r.alur = 6'($urandom);
         r.rw = 1'($urandom); r.mr = ($urandom_range(0, 2) == 0);
         r.mw = 1'($urandom); r.m2r = 1'($urandom);
         r.br = ($urandom_range(0, 3) == 0);
         r.wb_rw = 1'($urandom); r.wb_wr = 3'($urandom_range(0, 3));
         r.wb_data = 8'($urandom);
         @(negedge clk);
         drive(r);
         #1;
         if (n != 0) begin
            e1 = mdl_fwd(r.ex_rs, r.rf_d1, r.wb_rw, r.wb_wr, r.wb_data);
            e2 = mdl_fwd(r.ex_rt, r.rf_d2, r.wb_rw, r.wb_wr, r.wb_data);
            eh = mdl_haz(r.ex_rs, r.ex_rt);
            chk($sformatf("rnd%0d readd1", n), readd1, e1);
            chk($sformatf("rnd%0d readd2", n), readd2, e2);
            chk($sformatf("rnd%0d ld_hazard", n), ld_hazard, eh);
         end
         mdl_step(r);
         @(posedge clk);
         #1;
         chk($sformatf("rnd%0d m_RegWrite", n), m_RegWrite, s_rw);
         chk($sformatf("rnd%0d m_MemRead", n), m_MemRead, s_mr);
         chk($sformatf("rnd%0d m_MemWrite", n), m_MemWrite, s_mw);
         chk($sformatf("rnd%0d m_MemtoReg", n), m_MemtoReg, s_m2r);
         chk($sformatf("rnd%0d m_ALUResult", n), m_ALUResult, s_alu);
         chk($sformatf("rnd%0d m_WriteData", n), m_WriteData, s_wd);
         chk($sformatf("rnd%0d m_WriteReg", n), m_WriteReg, s_wr);
         chk($sformatf("rnd%0d m_ALUR", n), m_ALUR, s_alur);
         chk($sformatf("rnd%0d PCSrc", n), PCSrc, s_pcs);
         $display("rnd %0d rst=%0d stall=%0d flush=%0d rs=%0d rt=%0d rd1=%02h rd2=%02h ld=%0d m_rw=%0d m_mr=%0d m_wr=%0d pcs=%0d",
                  n, r.rst, r.stall, r.flush, r.ex_rs, r.ex_rt, readd1, readd2,
                  ld_hazard, m_RegWrite, m_MemRead, m_WriteReg, PCSrc);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
